// File: rtl/evseq_pkg.sv
// Shared definitions for the even-sequence generator/checker family:
// FSM states, sequence constants and word legality/successor helpers.
package evseq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } evseq_state_e;

  localparam logic [3:0] SEQ_STEP = 4'd2;
  localparam logic [3:0] SEQ_MAX  = 4'd8;

  function automatic logic is_legal(input logic [3:0] w);
    return (w <= SEQ_MAX) && !w[0];
  endfunction

  function automatic logic [3:0] next_even(input logic [3:0] w);
    return (w == SEQ_MAX) ? 4'd0 : w + SEQ_STEP;
  endfunction

endpackage

// File: rtl/evseq_next.sv
// Combinational legality check and successor of a 4-bit even-sequence word.
module evseq_next
  import evseq_pkg::*;
(
  input  logic [3:0] word,
  output logic       legal,
  output logic [3:0] succ
);

  assign legal = is_legal(word);
  assign succ  = next_even(word);

endmodule

// File: rtl/even_sequence_checker.sv
// Checks a 4-bit stream against 0,2,4,6,8,0,...: hunts, locks, then flags and counts mismatches.
// Define EVSEQ_AUTO_RESYNC_EN to drop lock after LOSS_COUNT consecutive mismatches.
module even_sequence_checker
  import evseq_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [0:3]           in_data,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [0:3]           expected
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  evseq_state_e         state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [3:0]           exp_q, exp_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic [3:0] in_word;
  logic       in_legal;
  logic [3:0] in_succ;
  logic       exp_legal_unused;
  logic [3:0] exp_succ;
  logic       match;

`ifdef EVSEQ_AUTO_RESYNC_EN
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);
  logic [MISS_W-1:0] miss_q, miss_d;
`else
  localparam int LOSS_COUNT_UNUSED = LOSS_COUNT;
`endif

  assign in_word = in_data;
  assign match   = (in_word == exp_q);

  evseq_next u_next_in  (.word(in_word), .legal(in_legal),         .succ(in_succ));
  evseq_next u_next_exp (.word(exp_q),   .legal(exp_legal_unused), .succ(exp_succ));

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
`ifdef EVSEQ_AUTO_RESYNC_EN
    miss_d  = miss_q;
`endif
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_legal) begin
            exp_d   = in_succ;
            run_d   = RUN_W'(1);
            state_d = (LOCK_COUNT == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (match) begin
            run_d = run_q + RUN_W'(1);
            exp_d = exp_succ;
            if (run_q == RUN_W'(LOCK_COUNT - 1)) state_d = LOCKED;
          end else if (in_legal) begin
            run_d = RUN_W'(1);
            exp_d = in_succ;
          end else begin
            run_d   = '0;
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: expected advances on mismatch too, never re-seeded from the input
          exp_d = exp_succ;
          if (match) begin
`ifdef EVSEQ_AUTO_RESYNC_EN
            miss_d = '0;
`endif
          end else begin
            err_d = 1'b1;
`ifdef EVSEQ_AUTO_RESYNC_EN
            if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
              miss_d  = '0;
              run_d   = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
`endif
          end
        end
        default: begin
          run_d   = '0;
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HUNT;
      run_q   <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
`ifdef EVSEQ_AUTO_RESYNC_EN
      miss_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
`ifdef EVSEQ_AUTO_RESYNC_EN
      miss_q  <= miss_d;
`endif
    end
  end

  // Clear has priority over a coincident mismatch; the counter sticks at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
    end else if (clear_err) begin
      err_count_q <= '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_q;
  assign err_count = err_count_q;
  assign expected  = exp_q;

endmodule

// File: tb/tb_even_sequence_checker.sv
// Scoreboard bench for even_sequence_checker: directed scenarios plus randomized stream
// against a behavioural model; follows EVSEQ_AUTO_RESYNC_EN when defined.
module tb_even_sequence_checker;

  localparam int LOCK_COUNT = 3;
  localparam int LOSS_COUNT = 2;
  localparam int ERR_CNT_W  = 2;
  localparam int CNT_MAX    = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 in_valid = 1'b0;
  logic [0:3]           in_data = '0;
  logic                 clear_err = 1'b0;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [0:3]           expected;

  even_sequence_checker #(
    .LOCK_COUNT(LOCK_COUNT),
    .LOSS_COUNT(LOSS_COUNT),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clear_err(clear_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .expected (expected)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit locked;
    bit pulse;
    int cnt;
    int exp;
  } obs_t;

  obs_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: alignment tracked as a count of consecutive good words
  // (0 = searching) plus a lock flag; words are plain integers.
  bit m_locked;
  int m_run;
  int m_miss;
  int m_exp;
  int m_cnt;

  function automatic bit legal_word(int w);
    return (w <= 8) && (w % 2 == 0);
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_run = 0; m_miss = 0; m_exp = 0; m_cnt = 0;
  endfunction

  function automatic obs_t model_step(bit v, int d, bit clr);
    obs_t o;
    bit   pulse = 0;
    if (v) begin
      if (m_locked) begin
        if (d == m_exp) m_miss = 0;
        else begin
          pulse = 1;
          m_miss++;
        end
        m_exp = (m_exp + 2) % 10;
`ifdef EVSEQ_AUTO_RESYNC_EN
        if (m_miss >= LOSS_COUNT) begin
          m_locked = 0; m_run = 0; m_miss = 0;
        end
`endif
      end else if (m_run == 0) begin
        if (legal_word(d)) begin
          m_exp = (d + 2) % 10;
          m_run = 1;
          if (m_run >= LOCK_COUNT) m_locked = 1;
        end
      end else begin
        if (d == m_exp) begin
          m_run++;
          m_exp = (m_exp + 2) % 10;
          if (m_run >= LOCK_COUNT) m_locked = 1;
        end else if (legal_word(d)) begin
          m_run = 1;
          m_exp = (d + 2) % 10;
        end else begin
          m_run = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
    else if (pulse && m_cnt < CNT_MAX) m_cnt++;
    o.locked = m_locked;
    o.pulse  = pulse;
    o.cnt    = m_cnt;
    o.exp    = m_exp;
    return o;
  endfunction

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic drive(bit v, int d, bit clr);
    @(negedge clk);
    in_valid  = v;
    in_data   = 4'(d);
    clear_err = clr;
    sb_q.push_back(model_step(v, d, clr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    clear_err = 1'b0;
    reset     = 1'b0;
    model_reset();
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_pulse", int'(err_pulse), 0);
    check("rst_err_count", int'(err_count), 0);
    check("rst_expected", int'(expected), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every clocked cycle carries one observation to compare
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      obs_t e;
      e = sb_q.pop_front();
      check("locked", int'(locked), int'(e.locked));
      check("err_pulse", int'(err_pulse), int'(e.pulse));
      check("err_count", int'(err_count), e.cnt);
      check("expected", int'(expected), e.exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    int seq2[5] = '{0, 2, 6, 8, 0};
    model_reset();
    do_reset();

    // Alignment with restart on a legal out-of-order word
    foreach (seq2[i]) drive(1, seq2[i], 0);

    // Locked run with in_valid gaps and the 8 -> 0 wrap
    drive(1, 2, 0); drive(0, 9, 0); drive(1, 4, 0); drive(0, 3, 0);
    drive(1, 6, 0); drive(1, 8, 0); drive(0, 0, 0); drive(1, 0, 0);

    // expected=4: a single bad word then the flywheel value
    drive(1, 2, 0); drive(1, 5, 0); drive(1, 6, 0);

    // Burst of mismatches for saturation, then clear coinciding with a mismatch
    drive(1, 8, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 0);
    drive(1, 1, 1);
    drive(0, 0, 0);

    // Re-lock, two back-to-back mismatches
    do_reset();
    drive(1, 4, 0); drive(1, 6, 0); drive(1, 8, 0);
    drive(1, 3, 0); drive(1, 7, 0);
    drive(1, 2, 0); drive(1, 4, 0);

    // Reset while locked mid-stream
    do_reset();
    drive(1, 0, 0); drive(1, 2, 0); drive(1, 4, 0); drive(1, 7, 0);
    do_reset();

    // Randomized stream, mostly in-sequence
    for (int i = 0; i < 400; i++) begin
      bit v   = ($urandom_range(0, 9) != 0);
      bit clr = ($urandom_range(0, 19) == 0);
      int d   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, 15)) : m_exp;
      drive(v, d, clr);
    end
    drive(0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
